// File: rtl/core_feed_pkg.sv
// Shared constants and FSM encoding for the SRAM-to-corelet feed sequencer.
package core_feed_pkg;

  // Dataflow mode, latched at start.
  localparam logic MODE_OS = 1'b0;
  localparam logic MODE_WS = 1'b1;

  // L0 source select in weight-stationary mode, latched at start.
  localparam logic SRC_ACT = 1'b0;
  localparam logic SRC_WT  = 1'b1;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feed_state_e;

endpackage

// File: rtl/core_feed_ctrl_skid.sv
// One-entry skid buffer placed in front of a destination that can refuse
// writes. A returning SRAM word is written straight through when the
// destination can take it, otherwise it is parked here until it can.
module feed_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  input  logic         full,
  output logic         wr,
  output logic [W-1:0] data,
  output logic         empty
);

  logic         vld_q, vld_d;
  logic [W-1:0] buf_q, buf_d;

  // Output selection and next skid contents. A parked word always goes out
  // before a newly returning one; the upstream issue rule never lets a new
  // word arrive while a parked word is still being refused.
  always_comb begin
    vld_d = vld_q;
    buf_d = buf_q;
    wr    = (vld_q | in_vld) & ~full;
    data  = '0;
    if (vld_q) begin
      data = buf_q;
    end else if (in_vld) begin
      data = in_data;
    end
    if (vld_q) begin
      if (!full) begin
        // Parked word accepted; a simultaneous return takes its place.
        vld_d = in_vld;
        if (in_vld) begin
          buf_d = in_data;
        end
      end
    end else if (in_vld && full) begin
      vld_d = 1'b1;
      buf_d = in_data;
    end
  end

  assign empty = ~vld_q;

  // Skid register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      buf_q <= '0;
    end else begin
      vld_q <= vld_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/core_feed_ctrl.sv
// SRAM-to-corelet feed sequencer. On start, reads len consecutive words from
// the activation/weight SRAM pair and writes them into L0 and/or the IFIFO
// depending on the latched dataflow mode, absorbing destination back-pressure
// with one skid entry per destination.
//
// Handshake: a destination write happens in any cycle where <dst>_wr is high;
// <dst>_wr is only ever high while <dst>_full is low, so every strobe is an
// accepted word. SRAM reads are issued with an active-low cen_* and data
// returns on q_* exactly one cycle later.
module core_feed_ctrl
  import core_feed_pkg::*;
#(
  parameter int BW     = 4,
  parameter int ROW    = 8,
  parameter int COL    = 8,
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              data_mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              cen_act,
  output logic              cen_wt,
  output logic [ADDR_W-1:0] sram_a,
  input  logic [BW*ROW-1:0] q_act,
  input  logic [BW*COL-1:0] q_wt,
  output logic [BW*ROW-1:0] l0_in,
  output logic              l0_wr,
  input  logic              l0_full,
  output logic [BW*COL-1:0] ififo_in,
  output logic              ififo_wr,
  input  logic              ififo_full,
  output logic [1:0]        state_dbg
);

  localparam int L0_W = BW * ROW;
  localparam int IF_W = BW * COL;

  feed_state_e       state_q, state_d;
  logic              mode_q, mode_d;
  logic              dmode_q, dmode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  l0_cnt_q, l0_cnt_d;
  logic [CNT_W-1:0]  if_cnt_q, if_cnt_d;
  logic              ret_vld_q, ret_vld_d;

  logic              os_act;
  logic              issue;
  logic              l0_skid_empty;
  logic              if_skid_empty;
  logic              if_in_vld;
  logic [L0_W-1:0]   wt_as_l0;
  logic [L0_W-1:0]   l0_src;

  assign os_act    = (mode_q == MODE_OS);
  assign state_dbg = state_q;

  // Weight words can only feed L0 when the two word widths agree.
  generate
    if (ROW == COL) begin : g_wt_to_l0
      assign wt_as_l0 = q_wt;
    end else begin : g_no_wt_to_l0
      assign wt_as_l0 = '0;
    end
  endgenerate

  // Read issue: only while words remain and every active destination could
  // take a word that returns next cycle without needing its skid twice.
  always_comb begin
    issue = 1'b0;
    if (state_q == ST_RUN && issued_q != len_q && l0_skid_empty && !l0_full) begin
      issue = os_act ? (if_skid_empty && !ififo_full) : 1'b1;
    end
  end

  // SRAM side: chip enables per active source, shared address wraps naturally.
  always_comb begin
    cen_act = 1'b1;
    cen_wt  = 1'b1;
    sram_a  = '0;
    if (issue) begin
      cen_act = ~(os_act || dmode_q == SRC_ACT);
      cen_wt  = ~(os_act || dmode_q == SRC_WT);
      sram_a  = base_q + issued_q[ADDR_W-1:0];
    end
  end

  // L0 source select: OS always takes activations, WS follows data_mode.
  always_comb begin
    l0_src = q_act;
    if (!os_act && dmode_q == SRC_WT) begin
      l0_src = wt_as_l0;
    end
  end

  assign if_in_vld = ret_vld_q & os_act;

  feed_skid #(.W(L0_W)) u_l0_skid (
    .clk     (clk),
    .rst     (reset),
    .in_vld  (ret_vld_q),
    .in_data (l0_src),
    .full    (l0_full),
    .wr      (l0_wr),
    .data    (l0_in),
    .empty   (l0_skid_empty)
  );

  feed_skid #(.W(IF_W)) u_if_skid (
    .clk     (clk),
    .rst     (reset),
    .in_vld  (if_in_vld),
    .in_data (q_wt),
    .full    (ififo_full),
    .wr      (ififo_wr),
    .data    (ififo_in),
    .empty   (if_skid_empty)
  );

  // Next-state, counters and status outputs.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    dmode_d   = dmode_q;
    base_d    = base_q;
    len_d     = len_q;
    issued_d  = issued_q + CNT_W'(issue);
    l0_cnt_d  = l0_cnt_q + CNT_W'(l0_wr);
    if_cnt_d  = if_cnt_q + CNT_W'(ififo_wr);
    ret_vld_d = issue;
    busy      = (state_q != ST_IDLE);
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d   = mode;
          dmode_d  = data_mode;
          base_d   = base_addr;
          len_d    = len;
          issued_d = '0;
          l0_cnt_d = '0;
          if_cnt_d = '0;
          state_d  = (len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issued_d == len_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A word is complete only once every active copy has been written.
        if (l0_cnt_d == len_q && (!os_act || if_cnt_d == len_q)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and transfer bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_OS;
      dmode_q   <= SRC_ACT;
      base_q    <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      l0_cnt_q  <= '0;
      if_cnt_q  <= '0;
      ret_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      dmode_q   <= dmode_d;
      base_q    <= base_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      l0_cnt_q  <= l0_cnt_d;
      if_cnt_q  <= if_cnt_d;
      ret_vld_q <= ret_vld_d;
    end
  end

endmodule

// File: tb/tb_core_feed_ctrl.sv
// Directed bench for core_feed_ctrl: a 1-cycle-latency SRAM pair model with
// address-derived contents, per-cycle strobe/address expectations, and an
// in-order scoreboard for each destination.
module tb_core_feed_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mode;
  logic          data_mode;
  logic [10:0]   base_addr;
  logic [11:0]   len;
  logic          busy;
  logic          done;
  logic          cen_act;
  logic          cen_wt;
  logic [10:0]   sram_a;
  logic [W-1:0]  q_act;
  logic [W-1:0]  q_wt;
  logic [W-1:0]  l0_in;
  logic          l0_wr;
  logic          l0_full;
  logic [W-1:0]  ififo_in;
  logic          ififo_wr;
  logic          ififo_full;
  logic [1:0]    state_dbg;

  int vectors = 0;
  int errs    = 0;

  logic [W-1:0] exp_l0_q[$];
  logic [W-1:0] exp_if_q[$];

  core_feed_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .data_mode  (data_mode),
    .base_addr  (base_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .cen_act    (cen_act),
    .cen_wt     (cen_wt),
    .sram_a     (sram_a),
    .q_act      (q_act),
    .q_wt       (q_wt),
    .l0_in      (l0_in),
    .l0_wr      (l0_wr),
    .l0_full    (l0_full),
    .ififo_in   (ififo_in),
    .ififo_wr   (ififo_wr),
    .ififo_full (ififo_full),
    .state_dbg  (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  function automatic logic [W-1:0] act_word(input logic [10:0] a);
    return {8'hA5, 13'h0, a};
  endfunction

  function automatic logic [W-1:0] wt_word(input logic [10:0] a);
    return {8'h3C, 13'h1F0F, a};
  endfunction

  // SRAM pair model: read data appears the cycle after an enabled access.
  always @(posedge clk) begin
    if (!cen_act) q_act <= act_word(sram_a);
    if (!cen_wt)  q_wt  <= wt_word(sram_a);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: every destination write must match the next expected word.
  always @(negedge clk) begin
    if (l0_wr === 1'b1) begin
      if (exp_l0_q.size() == 0) begin
        vectors++;
        errs++;
        $error("FAIL l0_extra_write observed=%0h expected=none", l0_in);
      end else begin
        chk("l0_data", l0_in, exp_l0_q.pop_front());
      end
    end
    if (ififo_wr === 1'b1) begin
      if (exp_if_q.size() == 0) begin
        vectors++;
        errs++;
        $error("FAIL ififo_extra_write observed=%0h expected=none", ififo_in);
      end else begin
        chk("ififo_data", ififo_in, exp_if_q.pop_front());
      end
    end
  end

  // One transfer with per-cycle expectations given as bit masks indexed by
  // cycle number after the start edge (cycle 1 = first cycle in RUN).
  task automatic run_xfer(input logic m, input logic dm, input logic [10:0] base,
                          input logic [11:0] n, input int ncyc,
                          input logic [15:0] ca_m, input logic [15:0] cw_m,
                          input logic [15:0] l0_m, input logic [15:0] if_m,
                          input logic [15:0] l0f_m, input logic [15:0] iff_m,
                          input logic [15:0] st_m, input int done_c);
    logic [10:0] a;
    a = base;
    for (int k = 0; k < int'(n); k++) begin
      if (m == 1'b0) begin
        exp_l0_q.push_back(act_word(a));
        exp_if_q.push_back(wt_word(a));
      end else if (dm) begin
        exp_l0_q.push_back(wt_word(a));
      end else begin
        exp_l0_q.push_back(act_word(a));
      end
      a = a + 11'd1;
    end
    mode = m; data_mode = dm; base_addr = base; len = n; start = 1'b1;
    a = base;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      // Input changes after launch must have no effect.
      start = st_m[c]; base_addr = 11'h555; len = 12'd7; mode = ~m; data_mode = ~dm;
      l0_full = l0f_m[c]; ififo_full = iff_m[c];
      #1;
      chk("cen_act", cen_act, !ca_m[c]);
      chk("cen_wt", cen_wt, !cw_m[c]);
      if (ca_m[c] || cw_m[c]) begin
        chk("sram_a", sram_a, a);
        a = a + 11'd1;
      end else begin
        chk("sram_a_idle", sram_a, 0);
      end
      chk("l0_wr", l0_wr, l0_m[c]);
      chk("ififo_wr", ififo_wr, if_m[c]);
      chk("done", done, c == done_c);
      chk("busy", busy, c <= done_c);
      if (m) chk("ififo_in_ws", ififo_in, 0);
    end
    start = 1'b0; l0_full = 1'b0; ififo_full = 1'b0;
    chk("l0_pending", exp_l0_q.size(), 0);
    chk("ififo_pending", exp_if_q.size(), 0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cen_act"}, cen_act, 1);
    chk({tag, "_cen_wt"}, cen_wt, 1);
    chk({tag, "_sram_a"}, sram_a, 0);
    chk({tag, "_l0_wr"}, l0_wr, 0);
    chk({tag, "_ififo_wr"}, ififo_wr, 0);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; data_mode = 1'b0;
    base_addr = '0; len = '0; l0_full = 1'b0; ififo_full = 1'b0;
    q_act = '0; q_wt = '0;
    #1;
    chk_reset_values("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // OS, base 0x10, len 4, no back-pressure.
    run_xfer(1'b0, 1'b0, 11'h010, 12'd4, 7,
             16'h001E, 16'h001E, 16'h003C, 16'h003C, 16'h0, 16'h0, 16'h0, 6);

    // WS weight->L0, len 3; start pulses during RUN must be ignored.
    run_xfer(1'b1, 1'b1, 11'h020, 12'd3, 6,
             16'h0000, 16'h000E, 16'h001C, 16'h0000, 16'h0, 16'h0, 16'h000C, 5);

    // OS with L0 full for 3 cycles while word 1 returns.
    run_xfer(1'b0, 1'b0, 11'h040, 12'd4, 11,
             16'h0186, 16'h0186, 16'h0344, 16'h030C, 16'h0038, 16'h0, 16'h0, 10);

    // OS with IFIFO full as word 0 returns: destinations drain independently.
    run_xfer(1'b0, 1'b0, 11'h060, 12'd2, 7,
             16'h0012, 16'h0012, 16'h0024, 16'h0028, 16'h0, 16'h0004, 16'h0, 6);

    // WS activation->L0, len 2.
    run_xfer(1'b1, 1'b0, 11'h005, 12'd2, 5,
             16'h0006, 16'h0000, 16'h000C, 16'h0000, 16'h0, 16'h0, 16'h0, 4);

    // len 0: done the cycle after start, no SRAM activity.
    run_xfer(1'b0, 1'b0, 11'h033, 12'd0, 2,
             16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1);

    // Reset in the middle of an OS transfer: two words land before the abort.
    exp_l0_q.push_back(act_word(11'h000)); exp_l0_q.push_back(act_word(11'h001));
    exp_if_q.push_back(wt_word(11'h000));  exp_if_q.push_back(wt_word(11'h001));
    mode = 1'b0; data_mode = 1'b0; base_addr = 11'h000; len = 12'd8; start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk_reset_values("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_l0_pending", exp_l0_q.size(), 0);
    chk("midrst_ififo_pending", exp_if_q.size(), 0);

    // Address wrap after reset: 0x7FE, 0x7FF, 0x000, 0x001.
    run_xfer(1'b0, 1'b0, 11'h7FE, 12'd4, 7,
             16'h001E, 16'h001E, 16'h003C, 16'h003C, 16'h0, 16'h0, 16'h0, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
